// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled UART receiver feeding the ALU command interface.
// Frames are start bit, SIZEDATA data bits (LSB first), optional even-parity bit, stop bit.
// Optional feature: define UART_RX_PARITY_EN to add the PARITY state. The port list is
// identical in both builds.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_rx         serial line, idles high, asynchronous to i_clock
//   o_rx_done    one-cycle strobe, o_rx_data holds a new good byte
//   o_rx_data    last good byte, held until the next good byte
//   o_frame_err  one-cycle strobe, stop bit low (or parity mismatch)
//   o_busy       high whenever the receiver is not idle
module uart_rx_frontend #(
  parameter int unsigned SIZEDATA   = 8,
  parameter int unsigned DIVISOR    = 163,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic                i_rx,
  output logic                o_rx_done,
  output logic [SIZEDATA-1:0] o_rx_data,
  output logic                o_frame_err,
  output logic                o_busy
);

  localparam int unsigned DivW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int unsigned BitW = $clog2(SIZEDATA + 1);

  localparam logic [DivW-1:0] DivLast  = DivW'(DIVISOR - 1);
  localparam logic [3:0]      TickHalf = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]      TickLast = 4'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(SIZEDATA - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // Two-flop synchroniser, reset to the idle line level.
  logic r_rx_meta;
  logic r_rx_s;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Free-running oversample tick; never re-phased by frame starts.
  logic [DivW-1:0] r_div_cnt;
  logic            w_tick;

  assign w_tick = (r_div_cnt == DivLast);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DivW'(1);
    end
  end

  state_e              r_state;
  logic [3:0]          r_tick_cnt;
  logic [BitW-1:0]     r_bit_cnt;
  logic [SIZEDATA-1:0] r_shift;
`ifdef UART_RX_PARITY_EN
  logic                r_par_err;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StIdle;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      o_rx_done   <= 1'b0;
      o_rx_data   <= '0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // Level-triggered: a line held low restarts a frame straight away.
          if (!r_rx_s) begin
            r_tick_cnt <= '0;
            r_state    <= StStart;
            o_busy     <= 1'b1;
          end
        end
        StStart: begin
          if (w_tick) begin
            if (r_tick_cnt == TickHalf) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              if (!r_rx_s) begin
                r_state <= StData;
              end else begin
                r_state <= StIdle;
                o_busy  <= 1'b0;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        StData: begin
          if (w_tick) begin
            if (r_tick_cnt == TickLast) begin
              r_tick_cnt <= '0;
              // LSB arrives first, so shift in from the top.
              r_shift    <= {r_rx_s, r_shift[SIZEDATA-1:1]};
              r_bit_cnt  <= r_bit_cnt + BitW'(1);
              if (r_bit_cnt == BitLast) begin
`ifdef UART_RX_PARITY_EN
                r_state <= StParity;
`else
                r_state <= StStop;
`endif
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        StParity: begin
`ifdef UART_RX_PARITY_EN
          if (w_tick) begin
            if (r_tick_cnt == TickLast) begin
              r_tick_cnt <= '0;
              // Even parity: parity bit equals XOR of the data bits.
              r_par_err  <= r_rx_s ^ (^r_shift);
              r_state    <= StStop;
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
`else
          r_state <= StIdle;
          o_busy  <= 1'b0;
`endif
        end
        StStop: begin
          if (w_tick) begin
            if (r_tick_cnt == TickLast) begin
              r_tick_cnt <= '0;
              r_state    <= StIdle;
              o_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
              if (r_rx_s && !r_par_err) begin
`else
              if (r_rx_s) begin
`endif
                o_rx_data <= r_shift;
                o_rx_done <= 1'b1;
              end else begin
                o_frame_err <= 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 4'd1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Self-checking bench for uart_rx_frontend with DIVISOR = 4 (one bit = 64 clocks).
// A frame-level model (queue of expected outcomes with arrival windows) is checked
// every cycle; literal expectations after each scenario pin the model.
module tb_uart_rx_frontend;

  localparam int D   = 4;
  localparam int BIT = 16 * D;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif
  // Strobe window in clocks from the start-bit edge: sync + start-half + NB full bits.
  localparam int Lo = 4 + 7 * D + 16 * NB * D;
  localparam int Hi = 5 + 8 * D + 16 * NB * D;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       frame_err;
  logic       busy;

  uart_rx_frontend #(
    .SIZEDATA  (8),
    .DIVISOR   (D),
    .OVERSAMPLE(16)
  ) dut (
    .i_clock    (clk),
    .i_reset_n  (rst_n),
    .i_rx       (rx),
    .o_rx_done  (rx_done),
    .o_rx_data  (rx_data),
    .o_frame_err(frame_err),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         good;
    logic [7:0] data;
    int         t0;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] mdl_data = 8'h00;
  int         n_pass = 0;
  int         n_total = 0;
  int         n_done = 0;
  int         n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic clocks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Sends one frame; stop_len clocks of the stop bit carry 'stop', the rest is idle high.
  task automatic send(input logic [7:0] d, input bit stop, input bit par, input int stop_len);
    ev_t e;
    e.t0   = cyc;
    e.data = d;
`ifdef UART_RX_PARITY_EN
    e.good = stop && (par == ^d);
`else
    e.good = stop;
`endif
    exp_q.push_back(e);
    rx = 1'b0;
    clocks(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      clocks(BIT);
    end
`ifdef UART_RX_PARITY_EN
    rx = par;
    clocks(BIT);
`endif
    rx = stop;
    clocks(stop_len);
    rx = 1'b1;
    clocks(BIT - stop_len);
  endtask

  // Per-cycle comparison against the frame model.
  always @(negedge clk) begin
    ev_t e;
    int  dt;
    if (!rst_n) begin
      check("rst_done", rx_done, 0);
      check("rst_err", frame_err, 0);
      check("rst_busy", busy, 0);
      check("rst_data", rx_data, 0);
      mdl_data = 8'h00;
      exp_q.delete();
    end else begin
      if (rx_done) n_done++;
      if (frame_err) n_err++;
      if (rx_done || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {rx_done, frame_err}, 2'b00);
        end else begin
          e  = exp_q.pop_front();
          dt = cyc - e.t0;
          check("strobe_kind", {rx_done, frame_err}, e.good ? 2'b10 : 2'b01);
          check("strobe_window", (dt >= Lo) && (dt <= Hi), 1);
          if (e.good) mdl_data = e.data;
        end
      end else if (exp_q.size() != 0 && (cyc - exp_q[0].t0) > Hi) begin
        e = exp_q.pop_front();
        check("strobe_missing", {rx_done, frame_err}, e.good ? 2'b10 : 2'b01);
      end
      check("rx_data", rx_data, mdl_data);
    end
  end

  initial begin
    int d0;
    int e0;

    // Reset with idle line.
    clocks(5);
    check("reset_busy", busy, 0);
    check("reset_data", rx_data, 0);
    rst_n = 1'b1;
    clocks(10);

    // Single byte 0xA5.
    d0 = n_done;
    e0 = n_err;
    send(8'hA5, 1'b1, 1'b0, BIT);
    clocks(4);
    check("a5_done_count", n_done - d0, 1);
    check("a5_err_count", n_err - e0, 0);
    check("a5_data", rx_data, 8'hA5);
    check("a5_busy", busy, 0);

    // Framing error on 0x7F; stop bit low across its sample point only.
    d0 = n_done;
    e0 = n_err;
    send(8'h7F, 1'b0, 1'b1, 40);
    clocks(BIT);
    check("ferr_err_count", n_err - e0, 1);
    check("ferr_done_count", n_done - d0, 0);
    check("ferr_data_kept", rx_data, 8'hA5);
    check("ferr_busy", busy, 0);

    // Back-to-back bytes, no idle gap.
    d0 = n_done;
    send(8'h03, 1'b1, 1'b0, BIT);
    send(8'h05, 1'b1, 1'b0, BIT);
    send(8'h00, 1'b1, 1'b0, BIT);
    clocks(4);
    check("b2b_done_count", n_done - d0, 3);
    check("b2b_data", rx_data, 8'h00);

    // Start glitch: 12 clocks low.
    d0 = n_done;
    e0 = n_err;
    rx = 1'b0;
    clocks(12);
    rx = 1'b1;
    clocks(40);
    check("glitch_busy", busy, 0);
    check("glitch_strobes", (n_done - d0) + (n_err - e0), 0);
    clocks(BIT);

    // Mid-frame reset during data bit 4 of 0xFF, then 0x12.
    d0 = n_done;
    rx = 1'b0;
    clocks(BIT);
    rx = 1'b1;
    clocks(4 * BIT + 20);
    rst_n = 1'b0;
    clocks(3);
    rst_n = 1'b1;
    clocks(5 * BIT);
    check("mrst_no_strobe", n_done - d0, 0);
    check("mrst_data", rx_data, 8'h00);
    check("mrst_busy", busy, 0);
    send(8'h12, 1'b1, 1'b0, BIT);
    clocks(4);
    check("after_rst_done_count", n_done - d0, 1);
    check("after_rst_data", rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    // Parity mismatch: 0x01 has odd weight, parity bit 0.
    d0 = n_done;
    e0 = n_err;
    send(8'h01, 1'b1, 1'b0, BIT);
    clocks(4);
    check("par_err_count", n_err - e0, 1);
    check("par_done_count", n_done - d0, 0);
    check("par_data_kept", rx_data, 8'h12);
`endif

    clocks(10);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
